pack_assemble: RTL and testbench

Upstream neighbour of the packet buffer/byte sender. Consumes the 16-bit word stream from the trace input interface, finds TPIU full-frame sync, strips halfword syncs, and assembles aligned 16-byte TPIU frames. Each completed frame is presented as a 128-bit word with a toggle-style availability flag, matching the buffer's edge-detecting write.

---
 rtl/pack_assemble_if.sv | 23 ++
 rtl/pack_assemble.sv | 106 ++++++++++
 tb/tb_pack_assemble.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pack_assemble_if.sv
// Handshake/bus bundle between the trace word source and the TPIU frame
// assembler. The master drives the halfword stream; the slave returns the
// assembled frame and sync status.
interface pack_assemble_if;
  logic         WdAvail;
  logic [15:0]  TraceWord;
  logic         Resync;
  logic         PkAvail;
  logic [127:0] Packet;
  logic         Synced;
  logic         SyncInd;
  logic         FrameDrop;

  modport master (
    output WdAvail, TraceWord, Resync,
    input  PkAvail, Packet, Synced, SyncInd, FrameDrop
  );

  modport slave (
    input  WdAvail, TraceWord, Resync,
    output PkAvail, Packet, Synced, SyncInd, FrameDrop
  );
endinterface

// File: rtl/pack_assemble.sv
// TPIU frame assembler: finds full-frame sync (FFFF,7FFF) in the halfword
// stream, strips halfword syncs (7FFF) and packs eight data halfwords into
// one 128-bit frame, announced by toggling PkAvail.
module pack_assemble #(
  parameter int STRETCHLOG2 = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  pack_assemble_if.slave  bus
);

  typedef enum logic {UNSYNC = 1'b0, RX_FRAME = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             count_q, count_d;
  logic                   lastv_q, lastv_d;
  logic [STRETCHLOG2-1:0] stretch_q, stretch_d;
  logic                   fdrop_d;
  logic [15:0]            last_q;
  logic [127:0]           asm_q;
  logic [127:0]           packet_q;
  logic                   pkavail_q;
  logic                   synced_q;
  logic                   fdrop_q;

  logic strobe;
  logic full_sync;
  logic store;
  logic complete;

  // A strobe coinciding with Resync is lost entirely.
  assign strobe    = bus.WdAvail && !bus.Resync;
  assign full_sync = strobe && lastv_q && (last_q == 16'hFFFF) &&
                     (bus.TraceWord == 16'h7FFF);
  assign store     = strobe && !full_sync && lastv_q &&
                     (last_q != 16'h7FFF) && (state_q == RX_FRAME);
  assign complete  = store && (count_q == 3'd7);

  // Next-state decode for sync state, halfword index, delay-line valid and stretch counter.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lastv_d   = lastv_q;
    stretch_d = (stretch_q != '0) ? stretch_q - 1'b1 : stretch_q;
    fdrop_d   = 1'b0;
    if (bus.Resync) begin
      state_d = UNSYNC;
      count_d = 3'd0;
      lastv_d = 1'b0;
    end else if (bus.WdAvail) begin
      lastv_d = 1'b1;
      if (full_sync) begin
        state_d   = RX_FRAME;
        count_d   = 3'd0;
        lastv_d   = 1'b0;
        stretch_d = '1;
        fdrop_d   = (state_q == RX_FRAME) && (count_q != 3'd0);
      end else if (store) begin
        // 7 -> 0 wrap coincides with frame completion.
        count_d = count_q + 3'd1;
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UNSYNC;
      count_q   <= 3'd0;
      lastv_q   <= 1'b0;
      stretch_q <= '0;
      packet_q  <= '0;
      pkavail_q <= 1'b0;
      synced_q  <= 1'b0;
      fdrop_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lastv_q   <= lastv_d;
      stretch_q <= stretch_d;
      synced_q  <= (state_d == RX_FRAME);
      fdrop_q   <= fdrop_d;
      if (complete) begin
        packet_q  <= {last_q, asm_q[111:0]};
        pkavail_q <= ~pkavail_q;
      end
    end
  end

  // Delay line and partial-frame assembly; contents are qualified by lastv_q/count_q.
  always_ff @(posedge clk) begin
    if (strobe) begin
      last_q <= bus.TraceWord;
    end
    if (store) begin
      asm_q[16*count_q +: 16] <= last_q;
    end
  end

  assign bus.PkAvail   = pkavail_q;
  assign bus.Packet    = packet_q;
  assign bus.Synced    = synced_q;
  assign bus.SyncInd   = (stretch_q != '0);
  assign bus.FrameDrop = fdrop_q;

endmodule

// File: tb/tb_pack_assemble.sv
// Directed bench for pack_assemble: sync acquisition, halfword-sync stripping,
// mid-frame resync, FFFF data, back-to-back frames, reset, Resync and SyncInd.
module tb_pack_assemble;

  localparam int SL2 = 6;   // small stretch counter keeps the SyncInd check short

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pack_assemble_if bus ();

  pack_assemble #(.STRETCHLOG2(SL2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    bus.TraceWord = w;
    bus.WdAvail   = 1'b1;
    @(posedge clk);
    #1;
    bus.WdAvail   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [127:0] pA, pB, p4;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.WdAvail = 1'b0;
    bus.TraceWord = 16'h0000;
    bus.Resync = 1'b0;
    idle(2);
    chk("rst_pkavail", bus.PkAvail, 0);
    chk("rst_packet", bus.Packet, 0);
    chk("rst_synced", bus.Synced, 0);
    chk("rst_syncind", bus.SyncInd, 0);
    chk("rst_fdrop", bus.FrameDrop, 0);
    rst_n = 1'b1;

    // Sync acquisition
    send(16'hFFFF);
    chk("pre_sync_synced", bus.Synced, 0);
    send(16'h7FFF);
    chk("acq_synced", bus.Synced, 1);
    chk("acq_syncind", bus.SyncInd, 1);
    chk("acq_nodrop", bus.FrameDrop, 0);
    for (int i = 1; i <= 8; i++) send(16'(i));
    chk("acq_pk_early", bus.PkAvail, 0);
    send(16'h7FFF);
    chk("acq_pkavail", bus.PkAvail, 1);
    chk("acq_packet", bus.Packet, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

    // Halfword-sync stripping
    send(16'h0011); send(16'h7FFF); send(16'h0022); send(16'h7FFF);
    for (int i = 3; i <= 8; i++) send(16'(i * 16'h0011));
    send(16'h7FFF);
    chk("strip_pkavail", bus.PkAvail, 0);
    chk("strip_packet", bus.Packet, 128'h0088_0077_0066_0055_0044_0033_0022_0011);

    // Mid-frame resync
    for (int i = 1; i <= 5; i++) send(16'(16'h0100 + i));
    send(16'hFFFF);
    chk("drop_pre", bus.FrameDrop, 0);
    send(16'h7FFF);
    chk("drop_pulse", bus.FrameDrop, 1);
    chk("drop_nopk", bus.PkAvail, 0);
    idle(1);
    chk("drop_end", bus.FrameDrop, 0);
    for (int i = 1; i <= 8; i++) send(16'(16'h0200 + i));
    send(16'h7FFF);
    chk("drop_pkavail", bus.PkAvail, 1);
    chk("drop_packet", bus.Packet, 128'h0208_0207_0206_0205_0204_0203_0202_0201);

    // FFFF as data
    send(16'h0301); send(16'h0302); send(16'hFFFF); send(16'h1234);
    for (int i = 5; i <= 8; i++) send(16'(16'h0300 + i));
    chk("ffff_synced", bus.Synced, 1);
    send(16'h7FFF);
    p4 = 128'h0308_0307_0306_0305_1234_FFFF_0302_0301;
    chk("ffff_pkavail", bus.PkAvail, 0);
    chk("ffff_idx2", bus.Packet[47:32], 16'hFFFF);
    chk("ffff_idx3", bus.Packet[63:48], 16'h1234);
    chk("ffff_packet", bus.Packet, p4);

    // Back-to-back frames on consecutive strobes
    pA = 128'h0408_0407_0406_0405_0404_0403_0402_0401;
    pB = 128'h0410_040F_040E_040D_040C_040B_040A_0409;
    for (int i = 0; i <= 16; i++) begin
      bus.TraceWord = (i < 16) ? 16'(16'h0401 + i) : 16'h7FFF;
      bus.WdAvail   = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("b2b_pk%0d", i), bus.PkAvail, (i >= 8 && i < 16) ? 1 : 0);
      chk($sformatf("b2b_pkt%0d", i), bus.Packet, (i < 8) ? p4 : ((i < 16) ? pA : pB));
    end
    bus.WdAvail = 1'b0;

    // Asynchronous reset mid-frame
    send(16'h0501); send(16'h0502); send(16'h0503);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_packet", bus.Packet, 0);
    chk("arst_pkavail", bus.PkAvail, 0);
    chk("arst_synced", bus.Synced, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(16'h0510 + i));
    send(16'h7FFF);
    chk("unsync_nopk", bus.PkAvail, 0);
    chk("unsync_synced", bus.Synced, 0);

    // Resync with a strobe
    send(16'hFFFF); send(16'h7FFF);
    chk("rs_synced", bus.Synced, 1);
    send(16'h0601); send(16'h0602); send(16'h0603);
    bus.Resync = 1'b1;
    send(16'h0604);
    bus.Resync = 1'b0;
    chk("rs_unsynced", bus.Synced, 0);
    chk("rs_nodrop", bus.FrameDrop, 0);
    for (int i = 1; i <= 8; i++) send(16'(16'h0700 + i));
    send(16'h7FFF);
    chk("rs_ignored_pk", bus.PkAvail, 0);
    chk("rs_ignored_pkt", bus.Packet, 0);
    send(16'hFFFF); send(16'h7FFF);
    for (int i = 1; i <= 8; i++) send(16'(16'h0800 + i));
    send(16'h7FFF);
    chk("rs_pkavail", bus.PkAvail, 1);
    chk("rs_packet", bus.Packet, 128'h0808_0807_0806_0805_0804_0803_0802_0801);

    // SyncInd stretch: counter loads 2^SL2-1 at the sync edge
    send(16'hFFFF); send(16'h7FFF);
    chk("si_nodrop", bus.FrameDrop, 0);
    chk("si_start", bus.SyncInd, 1);
    idle((1 << SL2) - 2);
    chk("si_last", bus.SyncInd, 1);
    idle(1);
    chk("si_expired", bus.SyncInd, 0);
    chk("si_synced", bus.Synced, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
